// File: rtl/wave_ram_writer.sv
// wave_ram_writer: double-banked 2 x 8 x 16-bit wave RAM.
//   The playback bank is selected by nr30[6]. The CPU only ever reads or
//   writes the other bank. A bank change is committed through a one-cycle
//   SWAP state, so it can never tear an access that is in flight.
// Ports:
//   system_clock       single clock, rising edge
//   reset              asynchronous, active low
//   nr30[6]            requested playback bank (other bits unused)
//   req_*              CPU request: valid/ready handshake, write, size (0=byte,
//                      1=halfword), byte offset 0..15, write data
//   resp_*             one-cycle completion pulse with read data / misalign flag
//   play_0x90..0x9E    halfwords of the committed playback bank
//   play_bank          committed playback bank
module wave_ram_writer #(
  parameter bit RESET_PLAY_BANK = 1'b0
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic [7:0]  nr30,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_size,
  input  logic [3:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] play_0x90,
  output logic [15:0] play_0x92,
  output logic [15:0] play_0x94,
  output logic [15:0] play_0x96,
  output logic [15:0] play_0x98,
  output logic [15:0] play_0x9A,
  output logic [15:0] play_0x9C,
  output logic [15:0] play_0x9E,
  output logic        play_bank
);
  typedef enum logic [1:0] {IDLE, ACCESS, SWAP} state_t;

  state_t                 state;
  logic [1:0][7:0][15:0]  mem;
  logic                   ready_en;   // low in the first cycle out of reset
  logic                   cap_bank, cap_write, cap_size;
  logic [3:0]             cap_addr;
  logic [15:0]            cap_wdata;

  logic        swap_pending, accept, req_misaligned, cap_misaligned;
  logic [15:0] rd_word, rd_data, wr_base, wr_word;
  logic        unused_nr30;

  assign unused_nr30    = ^{nr30[7], nr30[5:0]};
  assign swap_pending   = nr30[6] != play_bank;
  // A pending swap masks ready so it always wins over a simultaneous request.
  assign req_ready      = (state == IDLE) && ready_en && !swap_pending;
  assign accept         = req_valid && req_ready;
  assign req_misaligned = req_size && req_addr[0];
  assign cap_misaligned = cap_size && cap_addr[0];

  // Read path: the CPU side is always the non-playback bank.
  assign rd_word = mem[!play_bank][req_addr[3:1]];
  always_comb begin
    rd_data = 16'h0000;
    if (!req_misaligned) begin
      if (req_size)         rd_data = rd_word;
      else if (req_addr[0]) rd_data = {8'h00, rd_word[15:8]};
      else                  rd_data = {8'h00, rd_word[7:0]};
    end
  end

  // Write merge: a byte write keeps the other half of the halfword.
  assign wr_base = mem[cap_bank][cap_addr[3:1]];
  always_comb begin
    wr_word = cap_wdata;
    if (!cap_size) begin
      if (cap_addr[0]) wr_word = {cap_wdata[7:0], wr_base[7:0]};
      else             wr_word = {wr_base[15:8], cap_wdata[7:0]};
    end
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      play_bank  <= RESET_PLAY_BANK;
      mem        <= '0;
      ready_en   <= 1'b0;
      cap_bank   <= 1'b0;
      cap_write  <= 1'b0;
      cap_size   <= 1'b0;
      cap_addr   <= 4'h0;
      cap_wdata  <= 16'h0000;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 16'h0000;
    end else begin
      ready_en   <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 16'h0000;
      case (state)
        IDLE: begin
          if (swap_pending) begin
            state <= SWAP;
          end else if (accept) begin
            state      <= ACCESS;
            cap_bank   <= !play_bank;
            cap_write  <= req_write;
            cap_size   <= req_size;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            // Response registers go live for the ACCESS cycle.
            resp_valid <= 1'b1;
            resp_err   <= req_misaligned;
            resp_rdata <= req_write ? 16'h0000 : rd_data;
          end
        end
        ACCESS: begin
          if (cap_write && !cap_misaligned)
            mem[cap_bank][cap_addr[3:1]] <= wr_word;
          state <= swap_pending ? SWAP : IDLE;
        end
        SWAP: begin
          // Re-sampled here: a request that bounced back means no change.
          play_bank <= nr30[6];
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The playback bank is never written by the CPU, so these are glitch-free.
  assign play_0x90 = mem[play_bank][0];
  assign play_0x92 = mem[play_bank][1];
  assign play_0x94 = mem[play_bank][2];
  assign play_0x96 = mem[play_bank][3];
  assign play_0x98 = mem[play_bank][4];
  assign play_0x9A = mem[play_bank][5];
  assign play_0x9C = mem[play_bank][6];
  assign play_0x9E = mem[play_bank][7];
endmodule

// File: doc/wave_ram_writer.md
WAVE_RAM_WRITER -- requirements
Module: wave_ram_writer

Interface
REQ-001 The module SHALL have parameter RESET_PLAY_BANK, default 0, giving the playback bank after reset.
REQ-002 The module SHALL have port system_clock, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port nr30, input, 8 bits: bit 6 is the requested playback bank; other bits are ignored.
REQ-005 The module SHALL have port req_valid, input, 1 bit: the CPU access request.
REQ-006 The module SHALL have port req_ready, output, 1 bit: the module can accept a request.
REQ-007 The module SHALL have port req_write, input, 1 bit: 1 means write, 0 means read.
REQ-008 The module SHALL have port req_size, input, 1 bit: 0 means byte, 1 means halfword.
REQ-009 The module SHALL have port req_addr, input, 4 bits: byte offset within 0x90-0x9F.
REQ-010 The module SHALL have port req_wdata, input, 16 bits: write data; byte writes use [7:0].
REQ-011 The module SHALL have port resp_valid, output, 1 bit: a one-cycle pulse marking completion.
REQ-012 The module SHALL have port resp_rdata, output, 16 bits: read data, valid with resp_valid.
REQ-013 The module SHALL have port resp_err, output, 1 bit: flags a misaligned halfword access, valid with resp_valid.
REQ-014 The module SHALL have ports play_0x90, play_0x92, ... play_0x9E, output, 16 bits each (8 ports): the halfwords of the playback bank.
REQ-015 The module SHALL have port play_bank, output, 1 bit: the currently committed playback bank.

Function
REQ-016 Storage SHALL be two banks of 8 x 16 bits; sample nibble order within a halfword SHALL be exactly as written.
REQ-017 CPU reads and writes SHALL always target bank !play_bank; the playback bank SHALL never be modified by the CPU.
REQ-018 The FSM SHALL have states IDLE, ACCESS and SWAP.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1; address, size, data and the target bank SHALL be captured on that edge.
REQ-021 In ACCESS, a write SHALL be committed to storage and resp_valid asserted, giving write latency = 1 cycle after acceptance.
REQ-022 In ACCESS, a read SHALL drive resp_rdata from the captured bank with resp_valid, giving read latency = 1 cycle.
REQ-023 The FSM SHALL return to IDLE, or go to SWAP if a swap is pending (REQ-027).
REQ-024 For a byte write, an even addr SHALL write [7:0] and an odd addr SHALL write [15:8] of halfword addr[3:1]; the other byte SHALL be unchanged.
REQ-025 For a byte read, resp_rdata SHALL be {8'h00, selected byte}.
REQ-026 A halfword access with addr[0]=1 SHALL not modify storage, SHALL return resp_rdata=0 and SHALL assert resp_err=1 with resp_valid; all other accesses SHALL return resp_err=0.
REQ-027 A bank swap SHALL be pending whenever nr30[6] != play_bank.
REQ-028 In IDLE with a pending swap, the FSM SHALL enter SWAP (req_ready=0) instead of accepting a request, and the swap SHALL take priority over a simultaneous req_valid.
REQ-029 In SWAP, play_bank SHALL become nr30[6] and play_* SHALL reflect the new bank on the next cycle; the FSM SHALL return to IDLE after 1 cycle.
REQ-030 An nr30[6] change during ACCESS SHALL be deferred until the access completes; an in-flight write SHALL land in the bank captured at acceptance.
REQ-031 If nr30[6] toggles and returns before being sampled in IDLE, no swap SHALL occur.
REQ-032 play_* SHALL be registered combinationally from the committed play_bank storage only, with no glitches from CPU writes.

Reset
REQ-033 While reset=0: FSM SHALL be IDLE, play_bank SHALL equal RESET_PLAY_BANK, all storage SHALL be 0, play_* SHALL be 0, req_ready SHALL be 0, and resp_valid, resp_err and resp_rdata SHALL be 0.
REQ-034 req_ready SHALL rise on the first clock after reset deasserts (if no swap is pending).
REQ-035 Reset asserted mid-access SHALL drop that access with no resp_valid.

Verification
REQ-036 Bench scenario: nr30=0x00, halfword write addr 0x0 data 0x2301, then read addr 0x0 -> write resp_valid 1 cycle after acceptance; read returns 0x2301, resp_err=0; play_0x90 stays 0x0000.
REQ-037 Bench scenario: byte write addr 0x3 data 0xAB, then byte write addr 0x2 data 0xCD -> halfword read addr 0x2 = 0xABCD.
REQ-038 Bench scenario: after REQ-036, set nr30=0x40 -> SWAP 1 cycle with req_ready=0; play_bank=1; play_0x90=0x2301; CPU now targets bank 0.
REQ-039 Bench scenario: halfword write addr 0x5 -> resp_err=1, resp_rdata=0, storage unchanged on readback.
REQ-040 Bench scenario: nr30[6] toggled in the same cycle a write is accepted -> write lands in the old non-play bank; SWAP follows ACCESS; play_* shows the written data.
REQ-041 Bench scenario: reset=0 asserted during ACCESS -> no resp_valid; all play_* = 0; play_bank = RESET_PLAY_BANK.
